apb_node_sync: RTL and testbench



---
 rtl/apb_node_pkg.sv | 21 ++
 rtl/apb_addr_decode.sv | 29 ++
 rtl/apb_node_sync.sv | 173 +++++++++++++++++
 tb/tb_apb_node_sync.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_node_pkg.sv
// Shared types and sizing helpers for the registered APB interconnect node.
// Combinational helpers only: no latency, no flow control of their own.
package apb_node_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // A disabled watchdog (0) still needs a 1-bit counter to keep the datapath legal.
  function automatic int cnt_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

  function automatic int idx_width(input int nb_master);
    return ($clog2(nb_master) < 1) ? 1 : $clog2(nb_master);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Priority address decoder: lowest matching inclusive range wins, START > END never hits.
// Purely combinational, zero latency, no backpressure.
module apb_addr_decode
  import apb_node_pkg::*;
#(
  parameter int NB_MASTER      = 8,
  parameter int APB_ADDR_WIDTH = 32,
  localparam int IDX_W         = idx_width(NB_MASTER)
) (
  input  logic [APB_ADDR_WIDTH-1:0]                addr,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] start_addr,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] end_addr,
  output logic                                     hit,
  output logic [IDX_W-1:0]                         idx
);

  // Scanning from the top down lets the lowest matching index overwrite the rest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NB_MASTER - 1; i >= 0; i--) begin
      if ((start_addr[i] <= addr) && (addr <= end_addr[i])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_node_sync.sv
// Registered APB node: decodes one upstream transfer and replays it SETUP/ACCESS downstream.
// Latency: hit = 3 cycles + slave waits (watchdog-capped), miss = 1 cycle; upstream held via pready_o.
module apb_node_sync
  import apb_node_pkg::*;
#(
  parameter int NB_MASTER      = 8,
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     psel_i,
  input  logic                                     penable_i,
  input  logic                                     pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]                paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]                prdata_o,
  output logic                                     pready_o,
  output logic                                     pslverr_o,
  output logic [NB_MASTER-1:0]                     psel_o,
  output logic [NB_MASTER-1:0]                     penable_o,
  output logic [NB_MASTER-1:0]                     pwrite_o,
  output logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NB_MASTER-1:0]                     pready_i,
  input  logic [NB_MASTER-1:0]                     pslverr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] END_ADDR_i,
  output logic                                     decerr_o,
  output logic                                     timeout_o
);

  localparam int IW   = idx_width(NB_MASTER);
  localparam int CW   = cnt_width(TIMEOUT_CYCLES);
  localparam int LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic                      write;
    logic [IW-1:0]             idx;
  } req_t;

  state_t        state;
  state_t        nxt_state;
  req_t          req_q;
  req_t          req_cur;
  logic [CW-1:0] cnt;
  logic          dec_hit;
  logic [IW-1:0] dec_idx;
  logic          start;
  logic          miss;
  logic          slv_rdy;
  logic          tmo;

  logic [NB_MASTER-1:0]                     psel_n;
  logic [NB_MASTER-1:0]                     penable_n;
  logic [NB_MASTER-1:0]                     pwrite_n;
  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] paddr_n;
  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] pwdata_n;
  logic [APB_DATA_WIDTH-1:0]                prdata_n;
  logic                                     pready_n;
  logic                                     pslverr_n;

  apb_addr_decode #(
    .NB_MASTER      (NB_MASTER),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH)
  ) u_decode (
    .addr       (paddr_i),
    .start_addr (START_ADDR_i),
    .end_addr   (END_ADDR_i),
    .hit        (dec_hit),
    .idx        (dec_idx)
  );

  assign start   = psel_i && !penable_i;
  assign miss    = (state == IDLE) && start && !dec_hit;
  assign slv_rdy = pready_i[req_q.idx];
  // A slave answering in the expiry cycle beats the watchdog.
  assign tmo     = (state == ACCESS) && !slv_rdy && (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // In IDLE the outgoing request comes straight from the upstream inputs so SETUP can start next cycle.
  always_comb begin
    req_cur = req_q;
    if (state == IDLE) begin
      req_cur.addr  = paddr_i;
      req_cur.wdata = pwdata_i;
      req_cur.write = pwrite_i;
      req_cur.idx   = dec_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      req_q     <= '0;
      cnt       <= '0;
      psel_o    <= '0;
      penable_o <= '0;
      pwrite_o  <= '0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      prdata_o  <= '0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      decerr_o  <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state <= nxt_state;
      if ((state == IDLE) && start) begin
        req_q <= req_cur;
      end
      if (state == SETUP) begin
        cnt <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + CW'(1);
      end
      psel_o    <= psel_n;
      penable_o <= penable_n;
      pwrite_o  <= pwrite_n;
      paddr_o   <= paddr_n;
      pwdata_o  <= pwdata_n;
      prdata_o  <= prdata_n;
      pready_o  <= pready_n;
      pslverr_o <= pslverr_n;
      decerr_o  <= miss;
      timeout_o <= tmo;
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (start) nxt_state = dec_hit ? SETUP : RESP;
      SETUP:   nxt_state = ACCESS;
      ACCESS:  if (slv_rdy || tmo) nxt_state = RESP;
      RESP:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state and registered, so every port is a flop.
  always_comb begin
    psel_n    = '0;
    penable_n = '0;
    pwrite_n  = '0;
    paddr_n   = '0;
    pwdata_n  = '0;
    prdata_n  = '0;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    if ((nxt_state == SETUP) || (nxt_state == ACCESS)) begin
      psel_n[req_cur.idx]    = 1'b1;
      penable_n[req_cur.idx] = (nxt_state == ACCESS);
      pwrite_n[req_cur.idx]  = req_cur.write;
      paddr_n[req_cur.idx]   = req_cur.addr;
      pwdata_n[req_cur.idx]  = req_cur.wdata;
    end
    if (nxt_state == RESP) begin
      pready_n = 1'b1;
      if (miss || tmo) begin
        pslverr_n = 1'b1;
      end else begin
        pslverr_n = pslverr_i[req_q.idx];
        prdata_n  = prdata_i[req_q.idx];
      end
    end
  end

endmodule

// File: tb/tb_apb_node_sync.sv
// Randomized bench for apb_node_sync against a transfer-level reference model.
// Reactive downstream slaves; every cycle of every transfer is checked.
module tb_apb_node_sync;

  localparam int NB = 8;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   psel, penable, pwrite;
  logic [AW-1:0]          paddr;
  logic [DW-1:0]          pwdata;
  logic [DW-1:0]          prdata;
  logic                   pready, pslverr;
  logic [NB-1:0]          m_psel, m_penable, m_pwrite;
  logic [NB-1:0][AW-1:0]  m_paddr;
  logic [NB-1:0][DW-1:0]  m_pwdata;
  logic [NB-1:0][DW-1:0]  m_prdata;
  logic [NB-1:0]          m_pready, m_pslverr;
  logic [NB-1:0][AW-1:0]  start_addr, end_addr;
  logic                   decerr, timeout;

  int n_chk = 0;
  int n_err = 0;

  apb_node_sync #(
    .NB_MASTER      (NB),
    .APB_DATA_WIDTH (DW),
    .APB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .psel_i       (psel),
    .penable_i    (penable),
    .pwrite_i     (pwrite),
    .paddr_i      (paddr),
    .pwdata_i     (pwdata),
    .prdata_o     (prdata),
    .pready_o     (pready),
    .pslverr_o    (pslverr),
    .psel_o       (m_psel),
    .penable_o    (m_penable),
    .pwrite_o     (m_pwrite),
    .paddr_o      (m_paddr),
    .pwdata_o     (m_pwdata),
    .prdata_i     (m_prdata),
    .pready_i     (m_pready),
    .pslverr_i    (m_pslverr),
    .START_ADDR_i (start_addr),
    .END_ADDR_i   (end_addr),
    .decerr_o     (decerr),
    .timeout_o    (timeout)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode: first port whose inclusive range contains the address.
  function automatic int model_port(input logic [AW-1:0] a);
    for (int i = 0; i < NB; i++) begin
      if (start_addr[i] <= a && a <= end_addr[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_map_directed();
    for (int i = 0; i < NB; i++) begin
      start_addr[i] = 32'hFFFF_FFFF;
      end_addr[i]   = 32'h0000_0000;
    end
    start_addr[0] = 32'h1000; end_addr[0] = 32'h1FFF;
    start_addr[1] = 32'h2000; end_addr[1] = 32'h20FF;
    start_addr[2] = 32'h1F00; end_addr[2] = 32'h2FFF;
    start_addr[3] = 32'h4000; end_addr[3] = 32'h4FFF;
    start_addr[4] = 32'h3000; end_addr[4] = 32'h2FFF;
  endtask

  task automatic random_map();
    logic [AW-1:0] s;
    for (int i = 0; i < NB; i++) begin
      s = $urandom_range(32'h0100, 32'hF000);
      start_addr[i] = s;
      if ($urandom_range(0, 5) == 0) end_addr[i] = s - 1 - $urandom_range(0, 255);
      else                           end_addr[i] = s + $urandom_range(0, 32'h1FFF);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pready"},  pready,    '0);
    check({tag, "_pslverr"}, pslverr,   '0);
    check({tag, "_prdata"},  prdata,    '0);
    check({tag, "_decerr"},  decerr,    '0);
    check({tag, "_timeout"}, timeout,   '0);
    check({tag, "_psel"},    m_psel,    '0);
    check({tag, "_penable"}, m_penable, '0);
    check({tag, "_pwrite"},  m_pwrite,  '0);
    check({tag, "_paddr"},   m_paddr,   '0);
    check({tag, "_pwdata"},  m_pwdata,  '0);
  endtask

  task automatic check_down(input int port, input bit act, input bit acc_ph, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [NB-1:0]         e_sel, e_en, e_wr;
    logic [NB-1:0][AW-1:0] e_a;
    logic [NB-1:0][DW-1:0] e_d;
    e_sel = '0; e_en = '0; e_wr = '0; e_a = '0; e_d = '0;
    if (act) begin
      e_sel[port] = 1'b1;
      e_en[port]  = acc_ph;
      e_wr[port]  = wr;
      e_a[port]   = a;
      e_d[port]   = d;
    end
    check("m_psel",    m_psel,    e_sel);
    check("m_penable", m_penable, e_en);
    check("m_pwrite",  m_pwrite,  e_wr);
    check("m_paddr",   m_paddr,   e_a);
    check("m_pwdata",  m_pwdata,  e_d);
  endtask

  task automatic check_up(input bit last, input bit e_err, input logic [DW-1:0] e_rd,
                          input bit e_dec, input bit e_tmo);
    check("pready",  pready,  last);
    check("pslverr", pslverr, last ? e_err : 1'b0);
    check("prdata",  prdata,  last ? e_rd : '0);
    check("decerr",  decerr,  last && e_dec);
    check("timeout", timeout, last && e_tmo);
  endtask

  // One upstream transfer; w = ACCESS cycles the slave waits before pready (>= TO never answers in time).
  task automatic do_xfer(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d,
                         input int w, input logic [DW-1:0] rdat, input logic serr, input bit scramble);
    int            port, lat, acc;
    bit            tmo;
    logic [DW-1:0] e_rd;
    logic          e_err;
    port = model_port(a);
    tmo  = (port >= 0) && (TO != 0) && (w >= TO);
    if (port < 0)  lat = 1;
    else if (tmo)  lat = TO + 2;
    else           lat = w + 3;
    e_rd  = '0;
    e_err = (port < 0) || tmo;
    acc   = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      if (k == 1 && scramble) random_map();
      m_pready  = NB'($urandom);
      m_pslverr = NB'($urandom);
      for (int i = 0; i < NB; i++) m_prdata[i] = $urandom;
      @(negedge clk);
      if (port >= 0) begin
        m_pready[port] = 1'b0;
        if (m_psel[port] && m_penable[port]) begin
          if (acc == w) begin
            m_pready[port]  = 1'b1;
            m_prdata[port]  = rdat;
            m_pslverr[port] = serr;
            e_rd  = rdat;
            e_err = serr;
          end
          acc++;
        end
      end
      check_down(port, (port >= 0) && (k < lat), (k >= 2), wr, a, d);
      check_up(k == lat, e_err, e_rd, port < 0, tmo);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic reset_mid();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h4020; pwrite = 1'b1; pwdata = $urandom;
    m_pready = '0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_access", m_penable, 8'h08);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int            p, w;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    m_prdata = '0; m_pready = '0; m_pslverr = '0;
    set_map_directed();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    do_xfer(32'h4010, 1'b1, 32'hDEADBEEF, 0, $urandom, 1'b0, 1'b0);
    do_xfer(32'h1004, 1'b0, $urandom, 3, 32'hA5A5A5A5, 1'b0, 1'b0);
    do_xfer(32'h9000, 1'b0, $urandom, 0, $urandom, 1'b0, 1'b0);
    do_xfer(32'h4000, 1'b1, $urandom, 100, $urandom, 1'b0, 1'b0);
    do_xfer(32'h4FFF, 1'b0, $urandom, TO - 1, 32'h1234_5678, 1'b0, 1'b0);
    do_xfer(32'h2000, 1'b1, $urandom, 1, $urandom, 1'b0, 1'b0);
    do_xfer(32'h2FFF, 1'b0, $urandom, 0, $urandom, 1'b0, 1'b0);
    do_xfer(32'h3000, 1'b0, $urandom, 0, $urandom, 1'b0, 1'b0);
    do_xfer(32'h1800, 1'b1, $urandom, 2, $urandom, 1'b1, 1'b1);
    idle(2);
    set_map_directed();
    reset_mid();
    do_xfer(32'h1000, 1'b0, $urandom, 1, 32'h0BAD_F00D, 1'b0, 1'b0);

    for (int n = 0; n < 250; n++) begin
      if (n % 25 == 0) random_map();
      if ($urandom_range(0, 1) == 0) begin
        a = $urandom_range(0, 32'hFFFF);
      end else begin
        p = $urandom_range(0, NB - 1);
        case ($urandom_range(0, 3))
          0:       a = start_addr[p];
          1:       a = start_addr[p] - 1;
          2:       a = end_addr[p];
          default: a = end_addr[p] + 1;
        endcase
      end
      w = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, TO);
      do_xfer(a, 1'($urandom), $urandom, w, $urandom, 1'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
